// File: rtl/periodic_deframer_pkg.sv
// periodic_deframer_pkg: state encoding, default settings-bus addresses and
// counter width shared between the periodic framer and deframer.
package periodic_deframer_pkg;

    localparam int unsigned CNT_W     = 16;
    localparam int unsigned SR_AWIDTH = 8;
    localparam int unsigned SR_DWIDTH = 32;

    localparam int unsigned DEF_SR_FRAME_LEN      = 0;
    localparam int unsigned DEF_SR_GAP_LEN        = 1;
    localparam int unsigned DEF_SR_OFFSET         = 2;
    localparam int unsigned DEF_SR_NUMBER_SYMBOLS = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OFFSET = 2'd1,
        ST_FRAME  = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    // A programmed length of zero is treated as one.
    function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_W'(1) : v;
    endfunction

endpackage

// File: rtl/setting_reg.sv
// setting_reg: one settings-bus register. Captures in when strobe is high
// and addr matches MY_ADDR; returns to AT_RESET on reset.
//   clk, reset     : clock, synchronous active-high reset
//   strobe/addr/in : settings bus write
//   out            : current register value
module setting_reg #(
    parameter int unsigned MY_ADDR  = 0,
    parameter int unsigned AWIDTH   = 8,
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned AT_RESET = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              strobe,
    input  logic [AWIDTH-1:0] addr,
    input  logic [WIDTH-1:0]  in,
    output logic [WIDTH-1:0]  out
);

    always_ff @(posedge clk) begin
        if (reset) begin
            out <= WIDTH'(AT_RESET);
        end else if (strobe && (addr == AWIDTH'(MY_ADDR))) begin
            out <= in;
        end
    end

endmodule

// File: rtl/periodic_deframer.sv
// periodic_deframer: rebuilds a continuous sample stream from a burst of
// tlast-delimited symbol frames: zero offset padding, zero gaps between
// symbols (first SKIP_GAPS gaps of a burst omitted), o_tlast at burst end.
//   clk, reset, clear          : clock, sync active-high reset, soft reset
//   set_stb/set_addr/set_data  : settings bus
//   i_tdata/i_tlast/i_tvalid/i_tready : symbol frames in
//   o_tdata/o_tlast/o_tvalid/o_tready : continuous stream out
//   sof/eof                    : first / last output beat of burst
//   err                        : sticky frame-length mismatch
module periodic_deframer
    import periodic_deframer_pkg::*;
#(
    parameter int unsigned SR_FRAME_LEN      = DEF_SR_FRAME_LEN,
    parameter int unsigned SR_GAP_LEN        = DEF_SR_GAP_LEN,
    parameter int unsigned SR_OFFSET         = DEF_SR_OFFSET,
    parameter int unsigned SR_NUMBER_SYMBOLS = DEF_SR_NUMBER_SYMBOLS,
    parameter int unsigned SKIP_GAPS         = 1,
    parameter int unsigned WIDTH             = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 set_stb,
    input  logic [SR_AWIDTH-1:0] set_addr,
    input  logic [SR_DWIDTH-1:0] set_data,
    input  logic [WIDTH-1:0]     i_tdata,
    input  logic                 i_tlast,
    input  logic                 i_tvalid,
    output logic                 i_tready,
    output logic [WIDTH-1:0]     o_tdata,
    output logic                 o_tlast,
    output logic                 o_tvalid,
    input  logic                 o_tready,
    output logic                 sof,
    output logic                 eof,
    output logic                 err
);

    logic [CNT_W-1:0] sr_frame_len, sr_gap_len, sr_offset, sr_num_sym;
    logic [CNT_W-1:0] frame_len_l, gap_len_l, offset_l, num_sym_l;
    logic [CNT_W-1:0] counter, sym_cnt, skip_cnt;
    state_t           state;
    logic             first;
    logic             beat, len_hit, frame_end, burst_end;
    logic             unused_set_hi;

    assign unused_set_hi = ^set_data[SR_DWIDTH-1:CNT_W];

    setting_reg #(.MY_ADDR(SR_FRAME_LEN), .AWIDTH(SR_AWIDTH), .WIDTH(CNT_W)) u_sr_frame_len (
        .clk(clk), .reset(reset), .strobe(set_stb), .addr(set_addr),
        .in(set_data[CNT_W-1:0]), .out(sr_frame_len));
    setting_reg #(.MY_ADDR(SR_GAP_LEN), .AWIDTH(SR_AWIDTH), .WIDTH(CNT_W)) u_sr_gap_len (
        .clk(clk), .reset(reset), .strobe(set_stb), .addr(set_addr),
        .in(set_data[CNT_W-1:0]), .out(sr_gap_len));
    setting_reg #(.MY_ADDR(SR_OFFSET), .AWIDTH(SR_AWIDTH), .WIDTH(CNT_W)) u_sr_offset (
        .clk(clk), .reset(reset), .strobe(set_stb), .addr(set_addr),
        .in(set_data[CNT_W-1:0]), .out(sr_offset));
    setting_reg #(.MY_ADDR(SR_NUMBER_SYMBOLS), .AWIDTH(SR_AWIDTH), .WIDTH(CNT_W)) u_sr_num_sym (
        .clk(clk), .reset(reset), .strobe(set_stb), .addr(set_addr),
        .in(set_data[CNT_W-1:0]), .out(sr_num_sym));

    // Stream muxing: zeros in OFFSET/GAP, pass-through in FRAME.
    always_comb begin
        o_tvalid  = 1'b0;
        o_tdata   = '0;
        i_tready  = 1'b0;
        case (state)
            ST_OFFSET, ST_GAP: o_tvalid = 1'b1;
            ST_FRAME: begin
                o_tvalid = i_tvalid;
                o_tdata  = i_tdata;
                i_tready = o_tready;
            end
            default: ;
        endcase
        beat      = o_tvalid && o_tready;
        len_hit   = (counter == frame_len_l);
        frame_end = (state == ST_FRAME) && beat && (len_hit || i_tlast);
        burst_end = frame_end && ((sym_cnt + CNT_W'(1)) == num_sym_l);
        o_tlast   = burst_end;
        eof       = burst_end;
        sof       = first && o_tvalid;
    end

    // Burst sequencing; settings are only sampled on IDLE exit.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state       <= ST_IDLE;
            counter     <= '0;
            sym_cnt     <= '0;
            skip_cnt    <= '0;
            first       <= 1'b0;
            err         <= 1'b0;
            frame_len_l <= CNT_W'(1);
            gap_len_l   <= '0;
            offset_l    <= '0;
            num_sym_l   <= CNT_W'(1);
        end else begin
            if (beat) begin
                first <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (i_tvalid) begin
                        frame_len_l <= at_least_one(sr_frame_len);
                        gap_len_l   <= sr_gap_len;
                        offset_l    <= sr_offset;
                        num_sym_l   <= at_least_one(sr_num_sym);
                        skip_cnt    <= '0;
                        sym_cnt     <= '0;
                        counter     <= CNT_W'(1);
                        first       <= 1'b1;
                        state       <= (sr_offset != '0) ? ST_OFFSET : ST_FRAME;
                    end
                end
                ST_OFFSET, ST_GAP: begin
                    if (beat) begin
                        if (counter == ((state == ST_OFFSET) ? offset_l : gap_len_l)) begin
                            state   <= ST_FRAME;
                            counter <= CNT_W'(1);
                        end else begin
                            counter <= counter + CNT_W'(1);
                        end
                    end
                end
                ST_FRAME: begin
                    if (frame_end) begin
                        // Length reached and tlast must coincide.
                        if (len_hit != i_tlast) begin
                            err <= 1'b1;
                        end
                        sym_cnt <= sym_cnt + CNT_W'(1);
                        counter <= CNT_W'(1);
                        if (burst_end) begin
                            state <= ST_IDLE;
                        end else if ((32'(skip_cnt) < SKIP_GAPS) || (gap_len_l == '0)) begin
                            if (skip_cnt != '1) begin
                                skip_cnt <= skip_cnt + CNT_W'(1);
                            end
                        end else begin
                            state <= ST_GAP;
                        end
                    end else if (beat) begin
                        counter <= counter + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_periodic_deframer.sv
// tb_periodic_deframer: directed checks of the periodic deframer output
// sequence, sof/eof/tlast flags, err stickiness, settings timing and reset.
module tb_periodic_deframer;
    import periodic_deframer_pkg::*;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset, clear, set_stb;
    logic [7:0]   set_addr;
    logic [31:0]  set_data;
    logic [W-1:0] i_tdata;
    logic         i_tlast, i_tvalid, i_tready;
    logic [W-1:0] o_tdata;
    logic         o_tlast, o_tvalid, o_tready;
    logic         sof, eof, err;

    int  n_cmp = 0;
    int  n_bad = 0;
    bit  bp_en = 1'b0;
    logic [34:0] cap_q[$];
    logic [34:0] exp_q[$];

    periodic_deframer #(.SKIP_GAPS(1), .WIDTH(W)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
        .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
        .sof(sof), .eof(eof), .err(err));

    always #5 clk = ~clk;

    // Output capture: {tlast, sof, eof, data} per accepted beat.
    always @(negedge clk) begin
        if (!reset && !clear && o_tvalid && o_tready)
            cap_q.push_back({o_tlast, sof, eof, o_tdata});
    end

    initial begin
        o_tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            o_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr_set(input logic [7:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        set_stb = 1'b1; set_addr = a; set_data = d;
        @(posedge clk); #1;
        set_stb = 1'b0;
    endtask

    task automatic configure(input int offset, input int gap, input int len, input int nsym);
        wr_set(8'(DEF_SR_OFFSET), 32'(offset));
        wr_set(8'(DEF_SR_GAP_LEN), 32'(gap));
        wr_set(8'(DEF_SR_FRAME_LEN), 32'(len));
        wr_set(8'(DEF_SR_NUMBER_SYMBOLS), 32'(nsym));
    endtask

    // Frame f sample k carries (f+1)*256 + k; early >= 0 puts tlast there and ends the frame.
    task automatic send_frames(input int nfr, input int len, input int early, input bit rv);
        bit acc;
        @(posedge clk); #1;
        for (int f = 0; f < nfr; f++) begin
            for (int k = 0; k < len; k++) begin
                if (rv) begin
                    repeat ($urandom_range(0, 2)) begin
                        i_tvalid = 1'b0;
                        @(posedge clk); #1;
                    end
                end
                i_tdata  = 32'((f + 1) * 256 + k);
                i_tlast  = (early >= 0) ? (k == early) : (k == len - 1);
                i_tvalid = 1'b1;
                acc = 1'b0;
                for (int c = 0; c < 300 && !acc; c++) begin
                    @(negedge clk);
                    acc = i_tready;
                    @(posedge clk); #1;
                end
                i_tvalid = 1'b0;
                if (!acc) begin
                    check("in_handshake_timeout", 32'(0), 32'(1));
                    return;
                end
                if (i_tlast) break;
            end
        end
        i_tlast = 1'b0;
    endtask

    task automatic build_exp(input int offset, input int gap, input int len, input int nsym);
        exp_q.delete();
        for (int i = 0; i < offset; i++) exp_q.push_back(35'(0));
        for (int s = 0; s < nsym; s++) begin
            for (int k = 0; k < len; k++) exp_q.push_back({3'b000, 32'((s + 1) * 256 + k)});
            if (s >= 1 && s < nsym - 1)
                for (int i = 0; i < gap; i++) exp_q.push_back(35'(0));
        end
        exp_q[0][33] = 1'b1;
        exp_q[exp_q.size() - 1][34] = 1'b1;
        exp_q[exp_q.size() - 1][32] = 1'b1;
    endtask

    task automatic finish_burst(input string tag);
        int n;
        for (int c = 0; c < 400 && cap_q.size() < exp_q.size(); c++) @(negedge clk);
        repeat (5) @(negedge clk);
        check({tag, "_len"}, 32'(cap_q.size()), 32'(exp_q.size()));
        n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_d%0d", tag, i), cap_q[i][31:0], exp_q[i][31:0]);
            check($sformatf("%s_lse%0d", tag, i), 32'(cap_q[i][34:32]), 32'(exp_q[i][34:32]));
        end
        cap_q.delete();
    endtask

    task automatic pulse(input bit is_reset);
        @(posedge clk); #1;
        if (is_reset) reset = 1'b1; else clear = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; clear = 1'b0;
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; set_stb = 1'b0; set_addr = '0; set_data = '0;
        i_tdata = '0; i_tlast = 1'b0; i_tvalid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_o_tvalid", 32'(o_tvalid), 32'(0));
        check("rst_i_tready", 32'(i_tready), 32'(0));
        check("rst_o_tlast", 32'(o_tlast), 32'(0));
        check("rst_sof", 32'(sof), 32'(0));
        check("rst_eof", 32'(eof), 32'(0));
        check("rst_err", 32'(err), 32'(0));
        @(posedge clk); #1;
        reset = 1'b0;

        // Offset 3, gap 2, three symbols, first gap skipped.
        configure(3, 2, 4, 3);
        build_exp(3, 2, 4, 3);
        cap_q.delete();
        send_frames(3, 4, -1, 1'b0);
        finish_burst("t1");

        // No offset, no gap: symbols back-to-back.
        configure(0, 0, 4, 2);
        build_exp(0, 0, 4, 2);
        send_frames(2, 4, -1, 1'b0);
        finish_burst("t2");

        // First case again under random backpressure on both sides.
        configure(3, 2, 4, 3);
        build_exp(3, 2, 4, 3);
        bp_en = 1'b1;
        send_frames(3, 4, -1, 1'b1);
        finish_burst("t3");
        bp_en = 1'b0;

        // Early tlast on the third sample: frame (and 1-symbol burst) ends there.
        configure(0, 0, 4, 1);
        build_exp(0, 0, 3, 1);
        send_frames(1, 4, 2, 1'b0);
        finish_burst("t4a");
        check("t4_err_set", 32'(err), 32'(1));
        build_exp(0, 0, 4, 1);
        send_frames(1, 4, -1, 1'b0);
        finish_burst("t4b");
        check("t4_err_sticky", 32'(err), 32'(1));
        pulse(1'b0);
        @(negedge clk);
        check("t4_err_clear", 32'(err), 32'(0));
        check("t4_clear_o_tvalid", 32'(o_tvalid), 32'(0));
        send_frames(1, 4, -1, 1'b0);
        finish_burst("t4c");
        check("t4_err_after", 32'(err), 32'(0));

        // Gap length written mid-burst only applies to the next burst.
        configure(3, 2, 4, 3);
        build_exp(3, 2, 4, 3);
        fork
            send_frames(3, 4, -1, 1'b0);
            begin
                repeat (8) @(posedge clk);
                wr_set(8'(DEF_SR_GAP_LEN), 32'(5));
            end
        join
        finish_burst("t5a");
        build_exp(3, 5, 4, 3);
        send_frames(3, 4, -1, 1'b0);
        finish_burst("t5b");

        // Reset while emitting a gap, then a fresh burst.
        configure(3, 2, 4, 3);
        cap_q.delete();
        fork
            send_frames(3, 4, -1, 1'b0);
        join_none
        for (int c = 0; c < 200 && cap_q.size() < 11; c++) @(negedge clk);
        check("t6_reach_gap", 32'(cap_q.size() >= 11), 32'(1));
        disable fork;
        i_tvalid = 1'b0; i_tlast = 1'b0;
        @(negedge clk);
        check("t6_in_gap", {30'(0), o_tvalid, i_tready}, 32'b10);
        check("t6_gap_data", o_tdata, 32'(0));
        pulse(1'b1);
        @(negedge clk);
        check("t6_rst_o_tvalid", 32'(o_tvalid), 32'(0));
        check("t6_rst_o_tlast", 32'(o_tlast), 32'(0));
        check("t6_rst_i_tready", 32'(i_tready), 32'(0));
        configure(3, 2, 4, 3);
        build_exp(3, 2, 4, 3);
        cap_q.delete();
        send_frames(3, 4, -1, 1'b0);
        finish_burst("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/periodic_deframer.md
# periodic_deframer

Transmit-side counterpart of the periodic framer. Accepts a burst of tlast-delimited symbol frames (frame_len samples each) and rebuilds a continuous sample stream: leading offset padding, zero-filled inter-symbol gaps (with the first SKIP_GAPS gaps of each burst omitted), and a single tlast marking end of burst. Sits in an RFNoC TX chain between the symbol-domain processing (e.g. IFFT) and the radio/DUC. Settings use the standard settings bus.

## Interface
- SR_FRAME_LEN, 0, settings address: samples per symbol frame (16 b)
- SR_GAP_LEN, 1, settings address: zero samples per inserted gap (16 b)
- SR_OFFSET, 2, settings address: zero samples before first symbol of burst (16 b)
- SR_NUMBER_SYMBOLS, 3, settings address: symbols per burst (16 b)
- SKIP_GAPS, 1, gaps omitted at burst start (0 = none)
- WIDTH, 32, sample width
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- clear  in  1  synchronous soft reset, same effect as reset except settings registers keep values
- set_stb / set_addr / set_data  in  1/8/32  settings bus
- i_tdata / i_tlast / i_tvalid  in  WIDTH/1/1  symbol frames
- i_tready  out  1
- o_tdata / o_tlast / o_tvalid  out  WIDTH/1/1  continuous stream; o_tlast = end of burst
- o_tready  in  1
- sof  out  1  high with first output beat of burst
- eof  out  1  high with last output beat of burst (= o_tlast)
- err  out  1  sticky frame-length mismatch flag

## Operation
- Settings registers: four setting_reg instances, 16 b. Values latched into working copies on IDLE exit; mid-burst writes take effect next burst. Latched frame_len 0 and number_symbols 0 are treated as 1.
- States: IDLE, OFFSET, FRAME, GAP. Counter 16 b, counts 1..N, boundary compare by ==.
- IDLE: o_tvalid=0, i_tready=0. On i_tvalid: latch settings, skip_cnt<=0, sym_cnt<=0, counter<=1; go OFFSET if offset!=0 else FRAME. No input consumed.
- OFFSET: o_tvalid=1, o_tdata=0, i_tready=0. Each accepted beat increments counter; on beat with counter==offset go FRAME, counter<=1.
- FRAME: pass-through: o_tdata=i_tdata, o_tvalid=i_tvalid, i_tready=o_tready. Frame ends on accepted beat where counter==frame_len or i_tlast=1. If those disagree, set err; frame still ends. At frame end sym_cnt++; if sym_cnt+1==number_symbols: o_tlast=1 on that beat, go IDLE. Else if skip_cnt<SKIP_GAPS or gap_len==0: skip_cnt++ (saturating), stay FRAME, counter<=1. Else GAP, counter<=1.
- GAP: as OFFSET with gap_len; exit to FRAME.
- sof = first accepted output beat after IDLE exit (OFFSET or FRAME); combinational from a registered "first" flag.
- i_tlast is not forwarded; o_tlast only at burst end.
- err cleared only by reset/clear.

## Timing
- Reset/clear: state IDLE, counters 0, err 0; o_tvalid 0, i_tready 0, o_tlast 0, sof 0, eof 0.
- IDLE->first output beat: 1 cycle after i_tvalid. FRAME data path combinational (0 latency). Burst end returns to IDLE; next burst restarts with 1-cycle bubble.
- AXI rules: o_tvalid never drops without handshake in OFFSET/GAP; in FRAME it follows i_tvalid. Counters advance only on o_tvalid&o_tready.
- Reset/clear mid-burst: abort immediately, partial burst lost, no o_tlast emitted.
- Simultaneous set_stb and IDLE exit: old value latched.

## Structure
- Shared include: state encoding localparams and default SR addresses shared with periodic_framer.
- No new sub-module; reuse setting_reg (x4). Single file, ~200 lines.

## Test plan
- frame_len=4, gap=2, offset=3, syms=3, SKIP_GAPS=1, input 3 frames -> output 0,0,0,F0[4],F1[4],0,0,F2[4]; o_tlast on last F2 beat; sof on first zero.
- offset=0, gap=0, syms=2 -> output F0,F1 back-to-back; sof on F0[0], eof on F1[3].
- Random o_tready/i_tvalid backpressure on first case -> identical output sequence, no lost or duplicated samples.
- Early i_tlast at 3rd sample of frame_len=4 -> frame ends after 3, err=1 and stays until clear.
- Write SR_GAP_LEN=5 mid-burst -> current burst keeps gap 2; next burst uses 5.
- Assert reset during GAP -> next cycle o_tvalid=0, state IDLE; fresh burst output correct.
